// File: rtl/buf_ptr_ctrl.sv
// Pointer controller for a circular buffer: write/read pointers, RAM addressing,
// registered occupancy flags and a burst sequencer that gates the read side.
module buf_ptr_ctrl #(
  parameter int unsigned c_width = 4,
  parameter int unsigned af_thr  = 12
) (
  input  logic               c_clk,
  input  logic               c_reset_n,
  input  logic               clear,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               wr_en,
  output logic [c_width-1:0] wr_addr,
  input  logic               start,
  input  logic [c_width:0]   burst_len,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               rd_en,
  output logic [c_width-1:0] rd_addr,
  output logic [c_width:0]   count,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PW    = c_width + 1;
  localparam int unsigned DEPTH = 1 << c_width;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   count_q, count_d;
  logic [PW-1:0]   remain_q;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            af_q, af_d;
  logic            busy_q, done_q;

  // Handshake gating of registered state; clear suppresses both transfers.
  assign s_ready     = !full_q;
  assign wr_en       = s_valid & !full_q & !clear;
  assign m_valid     = busy_q & !empty_q;
  assign rd_en       = m_valid & m_ready & !clear;
  assign wr_addr     = wr_ptr_q[c_width-1:0];
  assign rd_addr     = rd_ptr_q[c_width-1:0];
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign busy        = busy_q;
  assign done        = done_q;

  // Next pointers and flags, derived from the post-edge pointers so flags never lag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      rd_ptr_d = rd_ptr_q + PW'(rd_en);
    end
    count_d = wr_ptr_d - rd_ptr_d;
    full_d  = (count_d == PW'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= PW'(af_thr));
  end

  always_ff @(posedge c_clk or negedge c_reset_n) begin
    if (!c_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
    end
  end

  // Burst sequencer; busy/done are registered alongside the state.
  always_ff @(posedge c_clk or negedge c_reset_n) begin
    if (!c_reset_n) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (clear) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            remain_q <= burst_len;
            if (burst_len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_ACTIVE;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (rd_en) begin
            remain_q <= remain_q - PW'(1);
            if (remain_q == PW'(1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buf_ptr_ctrl.sv
// Scoreboard bench for buf_ptr_ctrl: a queue-based buffer/burst model predicts every
// cycle's outputs and the read data; a separate monitor pops and compares.
module tb_buf_ptr_ctrl;

  logic       c_clk = 1'b0;
  logic       c_reset_n = 1'b0;
  logic       clear = 1'b0, s_valid = 1'b0, start = 1'b0, m_ready = 1'b0;
  logic [4:0] burst_len = '0;
  logic       s_ready, wr_en, m_valid, rd_en, full, empty, almost_full, busy, done;
  logic [3:0] wr_addr, rd_addr;
  logic [4:0] count;

  buf_ptr_ctrl #(.c_width(4), .af_thr(12)) dut (
    .c_clk(c_clk), .c_reset_n(c_reset_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .start(start), .burst_len(burst_len),
    .m_valid(m_valid), .m_ready(m_ready), .rd_en(rd_en), .rd_addr(rd_addr),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .busy(busy), .done(done)
  );

  always #5 c_clk = ~c_clk;

  // External RAM: synchronous write, combinational read
  logic [7:0] wdata = '0;
  logic [7:0] ram [16];
  always @(posedge c_clk) if (wr_en) ram[wr_addr] <= wdata;

  typedef struct packed {
    logic       s_ready, wr_en;
    logic [3:0] wr_addr;
    logic       m_valid, rd_en;
    logic [3:0] rd_addr;
    logic [4:0] count;
    logic       full, empty, af, busy, done;
  } snap_t;

  snap_t      exp_q[$];
  logic [7:0] rd_exp_q[$];
  int         n_cmp = 0, n_bad = 0;

  // Reference model state
  logic [7:0] mq[$];
  int         wr_total = 0, rd_total = 0, left = 0;
  bit         in_burst = 0, done_p = 0;
  logic [7:0] next_data = 8'h00;

  task automatic model_reset();
    mq.delete();
    wr_total = 0; rd_total = 0; left = 0; in_burst = 0; done_p = 0;
  endtask

  task automatic cycle(input bit rn, input bit cl, input bit sv, input bit st,
                       input int len, input bit mr);
    snap_t e;
    bit    w, r, nd;
    @(negedge c_clk);
    c_reset_n = rn; clear = cl; s_valid = sv; start = st;
    burst_len = 5'(len); m_ready = mr; wdata = next_data;
    if (!rn) model_reset();
    w = sv && (mq.size() < 16) && !cl;
    r = in_burst && (mq.size() > 0) && mr && !cl;
    e.s_ready = (mq.size() < 16);
    e.wr_en   = w;
    e.wr_addr = 4'(wr_total % 16);
    e.m_valid = in_burst && (mq.size() > 0);
    e.rd_en   = r;
    e.rd_addr = 4'(rd_total % 16);
    e.count   = 5'(mq.size());
    e.full    = (mq.size() == 16);
    e.empty   = (mq.size() == 0);
    e.af      = (mq.size() >= 12);
    e.busy    = in_burst;
    e.done    = done_p;
    exp_q.push_back(e);
    if (!rn) return;
    if (cl) begin
      model_reset();
      return;
    end
    if (r) begin
      rd_exp_q.push_back(mq.pop_front());
      rd_total++;
    end
    if (w) begin
      mq.push_back(next_data);
      next_data++;
      wr_total++;
    end
    nd = 0;
    if (in_burst) begin
      if (r) begin
        left--;
        if (left == 0) begin in_burst = 0; nd = 1; end
      end
    end else if (!done_p && st) begin
      if (len == 0) nd = 1;
      else begin in_burst = 1; left = len; end
    end
    done_p = nd;
  endtask

  // Monitor: checks each cycle's outputs and the RAM word on every DUT pop
  initial begin
    snap_t      e, a;
    logic [7:0] d;
    forever begin
      @(negedge c_clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.s_ready = s_ready; a.wr_en = wr_en; a.wr_addr = wr_addr;
        a.m_valid = m_valid; a.rd_en = rd_en; a.rd_addr = rd_addr;
        a.count = count; a.full = full; a.empty = empty; a.af = almost_full;
        a.busy = busy; a.done = done;
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL status t=%0t got=%h want=%h (srdy,wen,waddr,mval,ren,raddr,cnt,full,empty,af,busy,done)",
                   $time, a, e);
        end
        if (rd_en === 1'b1 || e.rd_en) begin
          if (rd_exp_q.size() > 0) d = rd_exp_q.pop_front();
          else d = 8'hxx;
          if (rd_en === 1'b1) begin
            n_cmp++;
            if (ram[rd_addr] !== d) begin
              n_bad++;
              $display("FAIL rd_data t=%0t got=%h want=%h", $time, ram[rd_addr], d);
            end
          end
        end
      end
    end
  end

  initial begin
    // reset
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // 16 writes, no reads: reaches full, almost_full from count 12
    for (int i = 0; i < 16; i++) cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    // full with s_valid, start len=1, consumer ready
    cycle(1, 0, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, 1);
    // wrap: drain then 40-word interleaved traffic as bursts of 31 + 9
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 31, 0);
    for (int i = 0; i < 90; i++) cycle(1, 0, 1'(i % 2 == 0), 0, 0, 1'(i % 3 != 0));
    cycle(1, 0, 0, 1, 9, 0);
    for (int i = 0; i < 30; i++) cycle(1, 0, 1'(i % 2), 0, 0, 1);
    // zero-length burst
    cycle(1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 1);
    // len=8 starting empty; starved mid-burst
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 8, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 3, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0, 0, 1);
    // clear mid-burst with count 5, then reset mid-burst
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 20, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 20, 1);
    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rn, cl;
      rn = ($urandom_range(0, 299) != 0);
      cl = ($urandom_range(0, 79) == 0);
      cycle(rn, cl, rn && ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 20)), ($urandom_range(0, 3) != 0));
    end
    cycle(1, 0, 0, 0, 0, 0);
    @(negedge c_clk);
    @(negedge c_clk);
    #4;
    n_cmp++;
    if (exp_q.size() != 0 || rd_exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d/%0d want=0/0", exp_q.size(), rd_exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
